// File: rtl/calc_sequencer.sv
// calc_sequencer: sequences one calculator command per Enter rising edge.
//   load: Acc <= Operand; execute: present OP/A/B for SETTLE cycles, then Acc <= R.
//   Latency: edge to Done is 1 cycle (load) or SETTLE+1 cycles (execute).
//   Edges seen while Busy are dropped; Clear overrides everything synchronously.
// Ports:
//   Clock, Reset (async, active-high), Enter (async strobe), Clear (sync)
//   LoadMode/OpSel/Operand : command inputs sampled on an accepted edge
//   R, ovf                 : result/overflow from the external combinational calculator
//   OP, A, B               : calculator operands (A mirrors Acc)
//   Acc, OvfSticky, Busy, Done, OpCount : status / result outputs
module calc_sequencer #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enter,
  input  logic             Clear,
  input  logic             LoadMode,
  input  logic [2:0]       OpSel,
  input  logic [3:0]       Operand,
  input  logic [3:0]       R,
  input  logic             ovf,
  output logic [2:0]       OP,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic [3:0]       Acc,
  output logic             OvfSticky,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] OpCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    LOAD    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, next_state;
  logic       s1, s2, s3;
  logic       enter_edge;
  logic [3:0] settle_cnt;
  logic       complete;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= Enter;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign enter_edge = s2 & ~s3;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; edges are only accepted in IDLE, so edges while busy vanish.
  always_comb begin
    next_state = state;
    if (Clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (enter_edge) next_state = LoadMode ? LOAD : ISSUE;
        ISSUE:   if (settle_cnt == SETTLE_LAST) next_state = CAPTURE;
        CAPTURE: next_state = IDLE;
        LOAD:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    Busy     = (state != IDLE);
    complete = (state == CAPTURE) || (state == LOAD);
  end

  assign A = Acc;

  // Datapath registers. OP/B are only written in IDLE, which keeps them stable
  // for the whole ISSUE/CAPTURE window.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OP         <= 3'b000;
      B          <= 4'b0000;
      Acc        <= 4'b0000;
      OvfSticky  <= 1'b0;
      Done       <= 1'b0;
      OpCount    <= '0;
      settle_cnt <= 4'd0;
    end else begin
      Done <= complete & ~Clear;
      if (Clear) begin
        Acc       <= 4'b0000;
        OvfSticky <= 1'b0;
        OpCount   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (enter_edge) begin
              B <= Operand;
              if (!LoadMode) begin
                OP         <= OpSel;
                settle_cnt <= 4'd0;
              end
            end
          end
          ISSUE: settle_cnt <= settle_cnt + 4'd1;
          CAPTURE: begin
            Acc       <= R;
            OvfSticky <= OvfSticky | ovf;
            if (OpCount != '1) OpCount <= OpCount + CNT_W'(1);
          end
          LOAD: begin
            Acc <= B;
            if (OpCount != '1) OpCount <= OpCount + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected completions,
// a negedge monitor pops and compares on each Done.
module tb_calc_sequencer;

  localparam int SETTLE = 3;

  logic       clk = 1'b0;
  logic       Reset, Enter, Clear, LoadMode, ovf_in;
  logic [2:0] OpSel;
  logic [3:0] Operand, R;

  logic [2:0] OP,  OP2;
  logic [3:0] A, B, Acc, A2, B2, Acc2;
  logic       Sticky, Busy, Done, Sticky2, Busy2, Done2;
  logic [7:0] OpCount;
  logic [1:0] OpCount2;

  always #5 clk = ~clk;

  calc_sequencer #(.SETTLE(SETTLE), .CNT_W(8)) u_dut (
    .Clock(clk), .Reset(Reset), .Enter(Enter), .Clear(Clear), .LoadMode(LoadMode),
    .OpSel(OpSel), .Operand(Operand), .R(R), .ovf(ovf_in),
    .OP(OP), .A(A), .B(B), .Acc(Acc), .OvfSticky(Sticky), .Busy(Busy),
    .Done(Done), .OpCount(OpCount));

  calc_sequencer #(.SETTLE(1), .CNT_W(2)) u_dut2 (
    .Clock(clk), .Reset(Reset), .Enter(Enter), .Clear(Clear), .LoadMode(LoadMode),
    .OpSel(OpSel), .Operand(Operand), .R(R), .ovf(ovf_in),
    .OP(OP2), .A(A2), .B(B2), .Acc(Acc2), .OvfSticky(Sticky2), .Busy(Busy2),
    .Done(Done2), .OpCount(OpCount2));

  typedef struct {
    logic [3:0] acc;
    logic       sticky;
    int         cnt;
    int         cnt2;
    int         lat;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int enter_cyc = 0;

  // Reference model state
  logic [3:0] m_acc = 4'd0;
  logic       m_sticky = 1'b0;
  int         m_cnt = 0, m_cnt2 = 0;

  // Expected calculator inputs during an execute
  bit         cur_exec = 1'b0;
  logic [2:0] cur_op;
  logic [3:0] cur_a, cur_b;
  logic       prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!Reset) begin
      if (Busy && cur_exec) begin
        chk("hold_op", OP, cur_op);
        chk("hold_a", A, cur_a);
        chk("hold_b", B, cur_b);
      end
      if (Done) begin
        chk("done_not_back_to_back", prev_done, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("acc", Acc, e.acc);
          chk("a_eq_acc", A, e.acc);
          chk("sticky", Sticky, e.sticky);
          chk("opcount", OpCount, e.cnt);
          chk("latency", cyc - enter_cyc, e.lat);
          chk("acc_settle1", Acc2, e.acc);
          chk("opcount_w2", OpCount2, e.cnt2);
        end
      end
      prev_done <= Done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic model_clear();
    m_acc = 4'd0; m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic issue(input bit load, input logic [2:0] op, input logic [3:0] opnd,
                       input logic [3:0] r_v, input bit o_v, input bit bounce);
    exp_t e;
    int   t;
    for (int i = 0; i < 50 && (Busy || Busy2); i++) @(negedge clk);
    chk("idle_before_cmd", {Busy, Busy2}, 0);
    @(negedge clk);
    LoadMode = load; OpSel = op; Operand = opnd; R = r_v; ovf_in = o_v;
    cur_op = op; cur_b = opnd; cur_a = m_acc; cur_exec = !load;
    if (load) m_acc = opnd;
    else begin
      m_acc = r_v;
      m_sticky = m_sticky | o_v;
    end
    m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
    m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
    e.acc = m_acc; e.sticky = m_sticky; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    e.lat = load ? 4 : 3 + SETTLE + 1;
    sb.push_back(e);
    enter_cyc = cyc;
    Enter = 1'b1;
    // A bounce re-raises Enter while both instances are still busy.
    if (bounce) begin
      @(negedge clk); Enter = 1'b0;
      @(negedge clk); Enter = 1'b1;
    end else begin
      @(negedge clk); @(negedge clk);
    end
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", sb.size(), 0);
    Enter = 1'b0;
    cur_exec = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk); Clear = 1'b1;
    @(negedge clk); Clear = 1'b0;
    model_clear();
    chk("clear_acc", Acc, 0);
    chk("clear_sticky", Sticky, 0);
    chk("clear_opcount", OpCount, 0);
    chk("clear_opcount_w2", OpCount2, 0);
  endtask

  initial begin
    Reset = 1'b1; Enter = 1'b0; Clear = 1'b0; LoadMode = 1'b0;
    OpSel = 3'd0; Operand = 4'd0; R = 4'd0; ovf_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc", Acc, 0);
    chk("rst_a", A, 0);
    chk("rst_b", B, 0);
    chk("rst_op", OP, 0);
    chk("rst_sticky", Sticky, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_opcount", OpCount, 0);
    Reset = 1'b0;
    repeat (3) @(negedge clk);

    // Load 3, then execute 010 with R=5
    issue(1'b1, 3'd0, 4'b0011, 4'd0, 1'b0, 1'b0);
    issue(1'b0, 3'b010, 4'b0010, 4'b0101, 1'b0, 1'b0);
    // Overflow sticks across a clean execute, then Clear
    issue(1'b0, 3'b001, 4'd7, 4'b1000, 1'b1, 1'b0);
    issue(1'b0, 3'b100, 4'd1, 4'b0110, 1'b0, 1'b0);
    do_clear();
    // Second rise while busy is dropped
    issue(1'b0, 3'b011, 4'd4, 4'b1110, 1'b0, 1'b1);
    do_clear();
    // Saturation of the narrow counter: 1,2,3,3,3
    for (int i = 0; i < 5; i++) issue(1'b1, 3'd0, 4'(i + 1), 4'd0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      bit ld;
      ld = ($urandom_range(0, 2) == 0);
      issue(ld, 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
            !ld && ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 9) == 0) do_clear();
    end

    // Clear coincident with the detected edge: no command, no Done
    issue(1'b1, 3'd0, 4'd9, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    LoadMode = 1'b1; Operand = 4'd5; Enter = 1'b1;
    @(negedge clk); @(negedge clk);
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
    model_clear();
    repeat (6) @(negedge clk);
    Enter = 1'b0;
    chk("clr_edge_busy", {Busy, Busy2}, 0);
    chk("clr_edge_acc", Acc, 0);
    chk("clr_edge_opcount", OpCount, 0);
    repeat (4) @(negedge clk);

    // Load a value, then reset in the middle of an execute
    issue(1'b1, 3'd0, 4'd6, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    LoadMode = 1'b0; OpSel = 3'b111; Operand = 4'd3; R = 4'd12; ovf_in = 1'b1;
    Enter = 1'b1;
    repeat (4) @(negedge clk);
    chk("issue_busy_before_reset", Busy, 1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_acc", Acc, 0);
    chk("arst_b", B, 0);
    chk("arst_op", OP, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_sticky", Sticky, 0);
    chk("arst_opcount", OpCount, 0);
    Enter = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    model_clear();
    repeat (10) @(negedge clk);
    chk("post_reset_busy", {Busy, Busy2}, 0);
    chk("post_reset_opcount", OpCount, 0);
    chk("post_reset_acc", Acc, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
